// File: rtl/fifo_pkg.sv
// ----------------------------------------------------------------------------
// fifo_pkg
//   Shared definitions for the RegisterFile-backed FIFO controller:
//   default geometry, default almost-full/almost-empty thresholds and a
//   helper that sizes the occupancy counter for a given address width.
// ----------------------------------------------------------------------------
package fifo_pkg;

   localparam int DEF_AWIDTH   = 5;
   localparam int DEF_DWIDTH   = 16;
   localparam int DEF_DEPTH    = 2 ** DEF_AWIDTH;
   localparam int DEF_AF_LEVEL = 28;
   localparam int DEF_AE_LEVEL = 4;

   // The counter must hold 0..2**aw inclusive, which needs one extra bit.
   function automatic int cnt_width(input int aw);
      return aw + 1;
   endfunction

endpackage : fifo_pkg

// File: rtl/wrap_ptr.sv
// ----------------------------------------------------------------------------
// wrap_ptr
//   AWIDTH-bit pointer that increments on en and wraps naturally from
//   2**AWIDTH-1 back to 0.
// Ports:
//   clk   in   1        clock
//   rst   in   1        synchronous reset, active-high (highest priority)
//   clr   in   1        synchronous clear to 0
//   en    in   1        increment enable
//   ptr   out  AWIDTH   current pointer value (registered)
// ----------------------------------------------------------------------------
module wrap_ptr #(
   parameter int AWIDTH = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              en,
   output logic [AWIDTH-1:0] ptr
);

   logic [AWIDTH-1:0] ptr_r;

   // Pointer register: reset beats clear, clear beats increment.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_r <= {AWIDTH{1'b0}};
      end else if (clr) begin
         ptr_r <= {AWIDTH{1'b0}};
      end else if (en) begin
         ptr_r <= ptr_r + {{(AWIDTH-1){1'b0}}, 1'b1};
      end else begin
         ptr_r <= ptr_r;
      end
   end

   assign ptr = ptr_r;

endmodule : wrap_ptr

// File: rtl/regfile_fifo_ctrl.sv
// ----------------------------------------------------------------------------
// regfile_fifo_ctrl
//   Synchronous FIFO controller using an external RegisterFile as storage.
//   Converts valid/ready handshakes on both sides into RegisterFile write
//   enable/address/data and read address. Read data is combinational from
//   the RegisterFile, so the head entry is visible as soon as it is counted.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   flush                    synchronous clear of contents (rst wins)
//   in_valid/in_data/in_ready     producer stream
//   out_valid/out_data/out_ready  consumer stream (out_data = rf_rd_data)
//   rf_wr_en/rf_wr_addr/rf_wr_data  RegisterFile write port
//   rf_rd_addr/rf_rd_data           RegisterFile read port
//   level                    occupancy 0..DEPTH
//   almost_full              registered, level >= AF_LEVEL
//   almost_empty             registered, level <= AE_LEVEL
// ----------------------------------------------------------------------------
module regfile_fifo_ctrl
   import fifo_pkg::*;
#(
   parameter int AWIDTH   = DEF_AWIDTH,
   parameter int DWIDTH   = DEF_DWIDTH,
   parameter int AF_LEVEL = DEF_AF_LEVEL,
   parameter int AE_LEVEL = DEF_AE_LEVEL
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         in_valid,
   input  logic [DWIDTH-1:0]            in_data,
   output logic                         in_ready,
   output logic                         out_valid,
   output logic [DWIDTH-1:0]            out_data,
   input  logic                         out_ready,
   output logic                         rf_wr_en,
   output logic [AWIDTH-1:0]            rf_wr_addr,
   output logic [DWIDTH-1:0]            rf_wr_data,
   output logic [AWIDTH-1:0]            rf_rd_addr,
   input  logic [DWIDTH-1:0]            rf_rd_data,
   output logic [cnt_width(AWIDTH)-1:0] level,
   output logic                         almost_full,
   output logic                         almost_empty
);

   localparam int                CW       = cnt_width(AWIDTH);
   localparam int                DEPTH    = 2 ** AWIDTH;
   localparam logic [CW-1:0]     DEPTH_C  = CW'(DEPTH);
   localparam logic [CW-1:0]     AF_C     = CW'(AF_LEVEL);
   localparam logic [CW-1:0]     AE_C     = CW'(AE_LEVEL);
   localparam logic [CW-1:0]     ONE_C    = CW'(1);
   localparam logic [CW-1:0]     ZERO_C   = {CW{1'b0}};

   logic [CW-1:0]     count_r;
   logic [CW-1:0]     count_nxt_s;
   logic              af_r;
   logic              ae_r;
   logic              af_nxt_s;
   logic              ae_nxt_s;
   logic              full_s;
   logic              empty_s;
   logic              in_ready_s;
   logic              out_valid_s;
   logic              push_s;
   logic              pop_s;
   logic [AWIDTH-1:0] wr_ptr_s;
   logic [AWIDTH-1:0] rd_ptr_s;

   // Handshake qualification. Full/empty come straight from the count so a
   // pop while full cannot be turned into a same-cycle push.
   always_comb begin
      full_s      = (count_r == DEPTH_C);
      empty_s     = (count_r == ZERO_C);
      in_ready_s  = !rst && !full_s;
      out_valid_s = !rst && !empty_s;
      push_s      = in_valid && in_ready_s;
      pop_s       = out_valid_s && out_ready;
   end

   // Next occupancy and the flag values it implies; flush discards any
   // handshake of the same cycle.
   always_comb begin
      count_nxt_s = count_r;
      if (flush) begin
         count_nxt_s = ZERO_C;
      end else if (push_s && !pop_s) begin
         count_nxt_s = count_r + ONE_C;
      end else if (pop_s && !push_s) begin
         count_nxt_s = count_r - ONE_C;
      end else begin
         count_nxt_s = count_r;
      end
      af_nxt_s = (count_nxt_s >= AF_C);
      ae_nxt_s = (count_nxt_s <= AE_C);
   end

   // Occupancy and almost flags, registered together so flags track level.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_r <= ZERO_C;
         af_r    <= 1'b0;
         ae_r    <= 1'b1;
      end else begin
         count_r <= count_nxt_s;
         af_r    <= af_nxt_s;
         ae_r    <= ae_nxt_s;
      end
   end

   wrap_ptr #(.AWIDTH(AWIDTH)) u_wr_ptr (
      .clk (clk),
      .rst (rst),
      .clr (flush),
      .en  (push_s),
      .ptr (wr_ptr_s)
   );

   wrap_ptr #(.AWIDTH(AWIDTH)) u_rd_ptr (
      .clk (clk),
      .rst (rst),
      .clr (flush),
      .en  (pop_s),
      .ptr (rd_ptr_s)
   );

   assign in_ready     = in_ready_s;
   assign out_valid    = out_valid_s;
   assign out_data     = rf_rd_data;
   assign rf_wr_en     = push_s && !flush;
   assign rf_wr_addr   = wr_ptr_s;
   assign rf_wr_data   = in_data;
   assign rf_rd_addr   = rd_ptr_s;
   assign level        = count_r;
   assign almost_full  = af_r;
   assign almost_empty = ae_r;

endmodule : regfile_fifo_ctrl

// File: tb/tb_regfile_fifo_ctrl.sv
// ----------------------------------------------------------------------------
// tb_regfile_fifo_ctrl
//   Self-checking bench: a behavioural RegisterFile plus a queue-based FIFO
//   model; directed scenarios followed by a randomized phase.
// ----------------------------------------------------------------------------
module tb_regfile_fifo_ctrl;

   localparam int AW = 5;
   localparam int DW = 16;
   localparam int DEPTH = 32;
   localparam int AFL = 28;
   localparam int AEL = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_ready;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_ready = 1'b0;
   logic          rf_wr_en;
   logic [AW-1:0] rf_wr_addr;
   logic [DW-1:0] rf_wr_data;
   logic [AW-1:0] rf_rd_addr;
   logic [DW-1:0] rf_rd_data;
   logic [AW:0]   level;
   logic          almost_full;
   logic          almost_empty;

   int checks = 0;
   int errors = 0;

   // Reference model
   logic [DW-1:0] q[$];
   int            m_wr = 0;
   int            m_rd = 0;
   bit            m_af = 1'b0;
   bit            m_ae = 1'b1;
   bit            m_valid_known = 1'b0;
   bit            unread[DEPTH];

   logic [DW-1:0] mem[DEPTH];

   always #5 clk = ~clk;

   regfile_fifo_ctrl #(.AWIDTH(AW), .DWIDTH(DW), .AF_LEVEL(AFL), .AE_LEVEL(AEL)) dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_ready    (out_ready),
      .rf_wr_en     (rf_wr_en),
      .rf_wr_addr   (rf_wr_addr),
      .rf_wr_data   (rf_wr_data),
      .rf_rd_addr   (rf_rd_addr),
      .rf_rd_data   (rf_rd_data),
      .level        (level),
      .almost_full  (almost_full),
      .almost_empty (almost_empty)
   );

   always @(posedge clk) begin
      if (rf_wr_en) mem[rf_wr_addr] <= rf_wr_data;
   end
   assign rf_rd_data = mem[rf_rd_addr];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive at negedge, check just after, advance model at posedge.
   task automatic cycle(input bit r, input bit f, input bit iv, input logic [DW-1:0] d,
                        input bit ordy, input bit chk);
      bit exp_ir, exp_ov, exp_push, exp_pop;
      @(negedge clk);
      rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
      #1;
      exp_ir   = !r && (q.size() != DEPTH);
      exp_ov   = !r && (q.size() != 0);
      exp_push = iv && exp_ir;
      exp_pop  = exp_ov && ordy;
      if (chk && m_valid_known) begin
         check("in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
         check("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
         check("rf_wr_en", {31'd0, rf_wr_en}, {31'd0, exp_push && !f});
         check("level", {26'd0, level}, 32'(q.size()));
         check("almost_full", {31'd0, almost_full}, {31'd0, m_af});
         check("almost_empty", {31'd0, almost_empty}, {31'd0, m_ae});
         if (exp_ov && !r) begin
            check("out_data", {16'd0, out_data}, {16'd0, q[0]});
            check("rf_rd_addr", {27'd0, rf_rd_addr}, 32'(m_rd));
         end
         if (exp_push && !f) begin
            check("rf_wr_addr", {27'd0, rf_wr_addr}, 32'(m_wr));
            check("wr_free_slot", {31'd0, unread[rf_wr_addr]}, 32'd0);
         end
      end
      @(posedge clk);
      if (r || f) begin
         q.delete();
         m_wr = 0; m_rd = 0;
         foreach (unread[i]) unread[i] = 1'b0;
         if (r) m_valid_known = 1'b1;
      end else begin
         if (exp_pop) begin
            void'(q.pop_front());
            unread[m_rd] = 1'b0;
            m_rd = (m_rd + 1) % DEPTH;
         end
         if (exp_push) begin
            q.push_back(d);
            unread[m_wr] = 1'b1;
            m_wr = (m_wr + 1) % DEPTH;
         end
      end
      m_af = (q.size() >= AFL);
      m_ae = (q.size() <= AEL);
   endtask

   task automatic rnd_push(input bit ordy);
      cycle(1'b0, 1'b0, 1'b1, DW'($urandom_range(0, 65535)), ordy, 1'b1);
   endtask

   initial begin
      // Reset held two cycles with in_valid asserted
      cycle(1'b1, 1'b0, 1'b1, 16'h1111, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 16'h2222, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);

      // Single entry
      cycle(1'b0, 1'b0, 1'b1, 16'hA5A5, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
      check("single_level0", {26'd0, level}, 32'd0);

      // Fill to full, one refused push, then drain in order
      for (int i = 0; i < DEPTH; i++) rnd_push(1'b0);
      cycle(1'b0, 1'b0, 1'b1, 16'hDEAD, 1'b0, 1'b1);
      check("full_level", {26'd0, level}, 32'd32);
      for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);

      // Wrap: 31 loaded, 40 cycles of simultaneous push+pop, then drain
      for (int i = 0; i < 31; i++) rnd_push(1'b0);
      for (int i = 0; i < 40; i++) rnd_push(1'b1);
      check("wrap_level", {26'd0, level}, 32'd31);
      for (int i = 0; i < 31; i++) cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1);

      // Flush at level 10 with both handshakes active
      for (int i = 0; i < 10; i++) rnd_push(1'b0);
      cycle(1'b0, 1'b1, 1'b1, 16'hBEEF, 1'b1, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
      check("flush_level", {26'd0, level}, 32'd0);

      // Full + pop: 32 -> 31 -> 32
      for (int i = 0; i < DEPTH; i++) rnd_push(1'b0);
      cycle(1'b0, 1'b0, 1'b1, 16'h1234, 1'b1, 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 16'h5678, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
      check("fullpop_level", {26'd0, level}, 32'd32);
      for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1);

      // Randomized traffic with rare flushes and resets
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) == 0),
               1'($urandom_range(0, 1)), DW'($urandom_range(0, 65535)),
               1'($urandom_range(0, 1)), 1'b1);
      end
      cycle(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_regfile_fifo_ctrl
